im_loader: RTL
==============

# im_loader

Instruction-memory loader and store for the VLIW core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit halfwords. It writes them into a 32-entry × 16-bit instruction store, then serves the core's fetch port with a 32-bit instruction word `{mem[pc+1], mem[pc]}`. It is the write side of instruction memory: it replaces hard-coded reset contents with a runtime program load.

## Interface
Parameters:
- `DEPTH`, 32: number of halfword entries.
- `HW_W`, 16: halfword width.
- `AW`, 5: address width, log2(DEPTH).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `load_start`, in, 1: single-cycle request to begin a load. Sampled only in IDLE.
- `load_base`, in, AW: first halfword address. Sampled with `load_start`.
- `load_count`, in, AW+1: number of halfwords, valid range 0..32. Sampled with `load_start`.
- `s_valid`, in, 1: byte stream valid.
- `s_data`, in, 8: byte stream data.
- `s_ready`, out, 1: loader accepts a byte this cycle.
- `busy`, out, 1: load in progress, including the DONE cycle.
- `done`, out, 1: one-cycle pulse at load completion.
- `err`, out, 1: sticky; set by an illegal `load_count`, cleared by the next accepted `load_start` or by reset.
- `pc_5bits`, in, AW: fetch halfword address.
- `ir`, out, 32: fetched instruction word.

## Operation
- States:
  - IDLE: `s_ready`=0, `busy`=0.
  - LO: awaiting low byte.
  - HI: awaiting high byte.
  - DONE: one cycle.
- From IDLE, on `load_start`:
  - `load_count` = 0: go to DONE; no writes.
  - `load_count` > 32: set `err`, go to DONE; no writes.
  - Otherwise: latch `addr` = `load_base` and `remaining` = `load_count`, go to LO.
- LO: `s_ready`=1. On `s_valid` & `s_ready`, latch the byte into `lo_byte` and go to HI.
- HI: `s_ready`=1. On handshake, write `mem[addr] = {s_data, lo_byte}`, then `addr` = `addr`+1 mod 32 and `remaining` -= 1.
  - If the new `remaining` is 0, go to DONE.
  - Otherwise go to LO.
- DONE: assert `done`=1, `busy`=1, `s_ready`=0; go to IDLE the next cycle.
- Address wrap: `load_base` + `load_count` > 32 wraps modulo 32. This is legal and does not set `err`.
- `load_start` outside IDLE is ignored and has no effect on `err`.
- Fetch, combinational from the store:
  - `pc_5bits` in 0..30: `ir` = `{mem[pc+1], mem[pc]}`.
  - `pc_5bits` = 31: `ir` = `{16'h0000, mem[31]}`. No wrap to entry 0.
- While `busy`=1, `ir` = 32'h0 regardless of `pc_5bits`, so the core fetches NOPs during a load.
- Reset, including mid-load: all mem entries become 16'h0000, state goes to IDLE, a partial `lo_byte` is discarded, and `err`=0.
- Reset values: `s_ready`=0, `busy`=0, `done`=0, `err`=0, `ir`=32'h0.

## Timing
- `s_ready` is a registered function of state only. It does not depend on `s_valid`.
- Minimum 2 cycles per halfword. A full 32-halfword load with `s_valid` held high takes 64 accept cycles + 1 DONE cycle after the `load_start` cycle.
- A write issued at edge N is visible on `ir` from the first cycle with `busy`=0.
- `done` rises the cycle after the final HI handshake. `busy` falls one cycle after `done`.
- `load_start` with count 0 or >32: `busy` and `done` both high on the next cycle, for exactly one cycle.
- `s_valid` may stall arbitrarily in LO or HI. No timeout.
- Bytes presented while `s_ready`=0 are not consumed. The source must hold them.

## Structure
- Package `im_pkg`: `IM_DEPTH`=32, `IM_HW_W`=16, `IM_AW`=5, and the state enum `im_ld_state_t` {IDLE, LO, HI, DONE}.
- Sub-module `im_store`: DEPTH×HW_W register array with synchronous reset-to-zero, one write port, and two combinational read ports (pc, pc+1).
- Top `im_loader`: contains the FSM, address/count registers, `lo_byte`, `err`, and the fetch-word mux including the entry-31 and busy-gating cases.

## Test plan
- Reset, then read pc=0..31 -> `ir`=32'h0 for all; `s_ready`=0, `busy`=0.
- `load_start`, base=0, count=3, bytes 33,80,20,00,13,A2 -> mem[0]=8033, mem[1]=0020, mem[2]=A213; `done` pulses one cycle after the 6th byte. Then pc=0 gives `ir`=0020_8033 and pc=2 gives `ir`=0000_A213.
- Base=30, count=4, bytes 01..08 -> mem[30]=0201, mem[31]=0403, mem[0]=0605, mem[1]=0807; `err`=0. Then pc=31 gives `ir`=0000_0403.
- Count=40 -> `err`=1, one-cycle `done`, memory unchanged. Next valid `load_start` clears `err`.
- Random `s_valid` gaps during a count=2 load, plus `load_start` pulses mid-load -> same result as with no gaps; the extra starts are ignored; `ir`=0 throughout `busy`.
- Reset asserted after the LO byte of a load -> IDLE, all entries 0. A fresh load afterwards completes correctly with no stale `lo_byte`.

Source files
------------

// File: rtl/im_pkg.sv
// im_pkg: shared sizes and loader state encoding for the instruction-memory loader.
package im_pkg;
    localparam int IM_DEPTH = 32;
    localparam int IM_HW_W = 16;
    localparam int IM_AW = 5;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} im_ld_state_t;
endpackage

// File: rtl/im_store.sv
// im_store: halfword register array, reset to zero, one write port and two combinational read ports.
module im_store #(
    parameter int DEPTH = 32,
    parameter int HW_W = 16,
    parameter int AW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [HW_W-1:0] wdata,
    input  logic [AW-1:0]   raddr0,
    input  logic [AW-1:0]   raddr1,
    output logic [HW_W-1:0] rdata0,
    output logic [HW_W-1:0] rdata1
);
    logic [HW_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
endmodule

// File: rtl/im_loader.sv
// im_loader: byte-stream program loader into the instruction store, plus the core fetch port.
module im_loader
    import im_pkg::*;
#(
    parameter int DEPTH = IM_DEPTH,
    parameter int HW_W = IM_HW_W,
    parameter int AW = IM_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic [AW-1:0]   load_base,
    input  logic [AW:0]     load_count,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    input  logic [AW-1:0]   pc_5bits,
    output logic [2*HW_W-1:0] ir
);
    localparam logic [AW:0] MAX_COUNT = (AW+1)'(DEPTH);
    im_ld_state_t state;
    logic [AW-1:0] addr;
    logic [AW:0] remaining;
    logic [7:0] lo_byte;
    logic hs, we, bad_count;
    logic [HW_W-1:0] rd_lo, rd_hi;
    assign hs = s_valid && s_ready;
    assign we = (state == HI) && hs;
    assign bad_count = load_count > MAX_COUNT;
    im_store #(.DEPTH(DEPTH), .HW_W(HW_W), .AW(AW)) u_store (
        .clk(clk),
        .reset(reset),
        .we(we),
        .waddr(addr),
        .wdata({s_data, lo_byte}),
        .raddr0(pc_5bits),
        .raddr1(pc_5bits + AW'(1)),
        .rdata0(rd_lo),
        .rdata1(rd_hi)
    );
    // Outputs are registered alongside the state so s_ready never depends on s_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            addr <= '0;
            remaining <= '0;
            lo_byte <= '0;
        end else begin
            case (state)
                IDLE: if (load_start) begin
                    err <= bad_count;
                    busy <= 1'b1;
                    if (bad_count || load_count == '0) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else begin
                        state <= LO;
                        s_ready <= 1'b1;
                        addr <= load_base;
                        remaining <= load_count;
                    end
                end
                LO: if (hs) begin
                    lo_byte <= s_data;
                    state <= HI;
                end
                HI: if (hs) begin
                    addr <= addr + AW'(1);
                    remaining <= remaining - (AW+1)'(1);
                    if (remaining == (AW+1)'(1)) begin
                        state <= DONE;
                        s_ready <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= LO;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end
    // The last entry has no successor: its upper half reads as zero instead of wrapping.
    always_comb ir = busy ? '0 : (pc_5bits == AW'(DEPTH-1)) ? {HW_W'(0), rd_lo} : {rd_hi, rd_lo};
endmodule
